// File: rtl/d_branch_cmp_bht_pkg.sv
// Shared definitions for the decode-stage branch resolver: branch opcodes,
// 2-bit predictor counter states and the PC-to-table index helper.
package d_branch_cmp_bht_pkg;

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BLEZ = 3'd3;
    localparam logic [2:0] BR_BGTZ = 3'd4;
    localparam logic [2:0] BR_BLTZ = 3'd5;
    localparam logic [2:0] BR_BGEZ = 3'd6;
    localparam logic [2:0] BR_RSVD = 3'd7;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Word-aligned index: pc[idx_w+1:2]; callers truncate to idx_w bits.
    function automatic logic [31:0] bht_idx(input logic [31:0] pc, input int unsigned idx_w);
        return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
    endfunction

endpackage

// File: rtl/d_branch_cmp_bht_sat_ctr2.sv
// 2-bit saturating up/down counter with enable and async active-high reset.
module sat_ctr2
    import d_branch_cmp_bht_pkg::*;
#(
    parameter logic [1:0] INIT = WNT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       up,
    output logic [1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= INIT;
        end else if (en) begin
            if (up) begin
                if (q != ST) q <= q + 2'd1;
            end else begin
                if (q != SNT) q <= q - 2'd1;
            end
        end
    end

endmodule

// File: rtl/d_branch_cmp_bht.sv
// Decode-stage branch resolution with a table of 2-bit predictors read in F
// and trained in D, plus saturating branch/misprediction statistics.
module d_branch_cmp_bht
    import d_branch_cmp_bht_pkg::*;
#(
    parameter int         WIDTH     = 32,
    parameter int         BHT_DEPTH = 16,
    parameter logic [1:0] CTR_INIT  = 2'b01,
    parameter int         STAT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       pc_F,
    output logic              pred_F,
    input  logic              valid_D,
    input  logic              stall_D,
    input  logic [2:0]        br_op_D,
    input  logic [31:0]       pc_D,
    input  logic              pred_D,
    input  logic [WIDTH-1:0]  a1_D,
    input  logic [WIDTH-1:0]  a2_D,
    output logic              br_taken_D,
    output logic              mispredict_D,
    output logic [STAT_W-1:0] branch_cnt,
    output logic [STAT_W-1:0] mispred_cnt
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [IDX_W-1:0] idx_f;
    logic [IDX_W-1:0] idx_d;
    logic             resolve;
    logic             cond;
    logic             update;
    logic [1:0]       ctr [BHT_DEPTH];

    assign idx_f = IDX_W'(bht_idx(pc_F, IDX_W));
    assign idx_d = IDX_W'(bht_idx(pc_D, IDX_W));

    // Signed zero compares use the sign bit and a zero test to avoid signed casts.
    always_comb begin
        cond = 1'b0;
        case (br_op_D)
            BR_BEQ:  cond = (a1_D == a2_D);
            BR_BNE:  cond = (a1_D != a2_D);
            BR_BLEZ: cond = a1_D[WIDTH-1] || (a1_D == '0);
            BR_BGTZ: cond = !a1_D[WIDTH-1] && (a1_D != '0);
            BR_BLTZ: cond = a1_D[WIDTH-1];
            BR_BGEZ: cond = !a1_D[WIDTH-1];
            default: cond = 1'b0;
        endcase
    end

    assign resolve      = valid_D && (br_op_D != BR_NONE) && (br_op_D != BR_RSVD);
    assign br_taken_D   = resolve && cond;
    assign mispredict_D = resolve && (br_taken_D != pred_D);
    assign update       = resolve && !stall_D;

    for (genvar i = 0; i < BHT_DEPTH; i++) begin : g_bht
        sat_ctr2 #(.INIT(CTR_INIT)) u_ctr (
            .clk   (clk),
            .reset (reset),
            .en    (update && (idx_d == IDX_W'(i))),
            .up    (br_taken_D),
            .q     (ctr[i])
        );
    end

    // No write-to-read bypass: a same-index update shows up next cycle.
    assign pred_F = ctr[idx_f][1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (update) begin
            if (branch_cnt != '1) branch_cnt <= branch_cnt + 1'b1;
            if (mispredict_D && (mispred_cnt != '1)) mispred_cnt <= mispred_cnt + 1'b1;
        end
    end

endmodule

// File: doc/d_branch_cmp_bht.md
Name: d_branch_cmp_bht

Overview:
Decode-stage branch resolution unit for the pipelined MIPS core. It generalises the single-mode equality comparator to a parametrised operand width and a full set of MIPS conditional branches. It adds a BHT_DEPTH-entry table of 2-bit saturating counters, which the fetch stage reads for prediction and the decode stage updates on resolution. Mispredictions are flagged in D, and the block keeps branch and misprediction statistics.

Parameters:
WIDTH, 32, operand width of a1_D/a2_D (signed two's complement for zero-compare ops)
BHT_DEPTH, 16, number of counter entries; power of two, >= 2
CTR_INIT, 2'b01, reset value of every counter (weakly not-taken)
STAT_W, 16, width of statistic counters

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
pc_F  in  32  fetch-stage PC for prediction lookup
pred_F  out  1  prediction for pc_F (1 = taken)
valid_D  in  1  D-stage instruction valid
stall_D  in  1  D stage stalled this cycle
br_op_D  in  3  0 none, 1 beq, 2 bne, 3 blez, 4 bgtz, 5 bltz, 6 bgez, 7 none
pc_D  in  32  PC of D-stage instruction
pred_D  in  1  prediction made in F, carried in the F/D register
a1_D  in  WIDTH  forwarded rs value
a2_D  in  WIDTH  forwarded rt value
br_taken_D  out  1  resolved branch outcome
mispredict_D  out  1  resolved outcome differs from pred_D
branch_cnt  out  STAT_W  resolved branch count
mispred_cnt  out  STAT_W  misprediction count

Behaviour:
- Index: IDX_W = log2(BHT_DEPTH). idx(pc) = pc[IDX_W+1:2]. pc[1:0] ignored.
- Conditions (combinational; "resolve" = valid_D && br_op_D in 1..6):
  - beq: a1==a2
  - bne: a1!=a2
  - blez: signed a1<=0
  - bgtz: signed a1>0
  - bltz: a1[WIDTH-1]
  - bgez: !a1[WIDTH-1]
  - a2_D is ignored for ops 3-6.
- br_taken_D = resolve && condition. Forced 0 when not resolving, including op 0/7 or valid_D=0.
- mispredict_D = resolve && (br_taken_D != pred_D). It is combinational and does not depend on stall_D; the pipeline masks it while stalled.
- pred_F = bht[idx(pc_F)][1]. Combinational read of registered state, zero latency.
- Update condition: resolve && !stall_D.
  - On the clk edge when the update condition holds, bht[idx(pc_D)] moves one step.
  - Taken: +1, saturating at 2'b11. Not taken: -1, saturating at 2'b00.
  - Exactly one entry changes per cycle, at most.
- Same-cycle read/write to the same index: pred_F returns the pre-update value. There is no bypass; the new value is visible from the next cycle.
- Stats: on each update, branch_cnt += 1. If also mispredict_D, mispred_cnt += 1. Both saturate at all-ones (no wrap).
- Stalled cycles cause no table or stat change, even if the same branch is held for many cycles. Only the final unstalled cycle updates.
- Reset (async, level): all bht entries go to CTR_INIT and both stats go to 0, immediately. Reset asserted mid-update discards the update. The first update after deassertion occurs on the first clk edge with reset low.
- Reset values of outputs:
  - pred_F = CTR_INIT[1]
  - br_taken_D = 0 and mispredict_D = 0 if valid_D is low; otherwise they are combinational per the rules above
  - counters = 0
- X-safety: outputs must be driven (no X) whenever inputs are known.

Decomposition:
- Shared package/header holds:
  - br_op encodings (BR_NONE=0 .. BR_BGEZ=6)
  - counter state constants: SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11
  - the idx slicing macro
- Sub-module sat_ctr2 (2-bit saturating up/down counter with enable and async reset). Instantiate it BHT_DEPTH times via generate, or inline it as an array. The comparator logic stays in the top module.

Test Plan:
1. Reset then pc_F=0x3000 -> pred_F=0. Verify branch_cnt=0 and mispred_cnt=0.
2. beq, a1=a2=0x1234, pc_D=0x3004, pred_D=0, one unstalled cycle -> br_taken_D=1, mispredict_D=1. Next cycle: bht[1]=10, pred_F(0x3004)=1, branch_cnt=1, mispred_cnt=1.
3. bgtz a1=0x80000000 -> taken 0. blez a1=0 -> 1. bltz a1=-1 -> 1. bgez a1=0 -> 1. bne a1=5, a2=5 -> 0.
4. Four taken beq at pc 0x3008 -> counter saturates at 11. Then one not-taken -> 10, and pred stays 1.
5. Taken beq at pc_D=0x3010 held with stall_D=1 for 3 cycles, then released -> exactly one update, branch_cnt incremented by 1. Same cycle, pc_F=0x3010 -> pred_F shows the old value.
6. Assert reset asynchronously between edges during an update cycle -> table back to 01 and stats 0 immediately. With STAT_W=2, four mispredicts -> mispred_cnt stays 3.
